// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared constants for the stall/flush controller.
// Stage indices of pause[], FSM encoding and the `RegWidth address width.
`ifndef PIPE_STALL_CTRL_PKG_DEFS
`define PIPE_STALL_CTRL_PKG_DEFS
`define RegWidth 32
`endif

package pipe_stall_ctrl_pkg;

    localparam int PAUSE_W   = 6;
    localparam int PAUSE_PC  = 0;
    localparam int PAUSE_IF  = 1;
    localparam int PAUSE_ID  = 2;
    localparam int PAUSE_EX  = 3;
    localparam int PAUSE_MEM = 4;
    localparam int PAUSE_WB  = 5;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_REDIR = 1'b1
    } state_t;

    // Hold every stage from PC up to and including stage k.
    function automatic logic [PAUSE_W-1:0] stall_upto(input int k);
        logic [PAUSE_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAUSE_W; i++) begin
            m[i] = (i <= k);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: exception commit inputs and the redirect handshake.
// master = controller (drives redirect_pc*), slave = pipeline/fetch side.
interface pipe_stall_ctrl_if;

    logic                 excp_valid;
    logic                 excp_is_ertn;
    logic [`RegWidth-1:0] excp_entry;
    logic [`RegWidth-1:0] csr_era;
    logic                 redirect_ack;
    logic                 redirect_pc_valid;
    logic [`RegWidth-1:0] redirect_pc;

    modport master (
        input  excp_valid,
        input  excp_is_ertn,
        input  excp_entry,
        input  csr_era,
        input  redirect_ack,
        output redirect_pc_valid,
        output redirect_pc
    );

    modport slave (
        output excp_valid,
        output excp_is_ertn,
        output excp_entry,
        output csr_era,
        output redirect_ack,
        input  redirect_pc_valid,
        input  redirect_pc
    );

endinterface

// File: rtl/pipe_div_timer.sv
// pipe_div_timer: counts the EX stall cycles of a multi-cycle divide.
// Ports: clk, rst (async low), start/freeze/clear in; busy, done out.
module pipe_div_timer #(
    parameter int DIV_LATENCY = 17,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic freeze,
    input  logic clear,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    assign busy = (cnt != '0);

    // The start cycle itself is the first stall cycle, so loading
    // LATENCY-1 gives exactly LATENCY stall cycles before done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt <= LOAD;
            end else if (busy && !freeze) begin
                cnt  <= cnt - ONE;
                done <= (cnt == ONE);
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges stage stall requests into pause[5:0], times
// divides and runs the exception flush/redirect handshake.
// Ports: clk, rst (async low), *_stall_req, ex_div_start, redir (if),
// pause, flush, div_busy, div_done.
// Optional PIPE_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 17,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall_req,
    input  logic               id_stall_req,
    input  logic               ex_stall_req,
    input  logic               mem_stall_req,
    input  logic               ex_div_start,
    pipe_stall_ctrl_if.master  redir,
    output logic [PAUSE_W-1:0] pause,
    output logic               flush,
    output logic               div_busy,
    output logic               div_done
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    state_t               state;
    state_t               state_n;
    logic [PAUSE_W-1:0]   pause_c;
    logic                 flush_c;
    logic                 div_start;
    logic                 redir_load;
    logic                 redir_done;
    logic                 pc_valid;
    logic [`RegWidth-1:0] pc_q;
    logic [`RegWidth-1:0] pc_tgt;

    assign pc_tgt = redir.excp_is_ertn ? redir.csr_era : redir.excp_entry;

    always_comb begin
        state_n    = state;
        pause_c    = '0;
        flush_c    = 1'b0;
        div_start  = 1'b0;
        redir_load = 1'b0;
        redir_done = 1'b0;
        unique case (state)
            S_RUN: begin
                if (redir.excp_valid && !mem_stall_req) begin
                    flush_c    = 1'b1;
                    redir_load = 1'b1;
                    state_n    = S_REDIR;
                end else begin
                    // done blocks a restart while the source still holds start
                    div_start = ex_div_start && !div_busy && !div_done;
                    if (mem_stall_req) begin
                        pause_c = stall_upto(PAUSE_MEM);
                    end else if (ex_stall_req || div_start || div_busy) begin
                        pause_c = stall_upto(PAUSE_EX);
                    end else if (id_stall_req) begin
                        pause_c = stall_upto(PAUSE_ID);
                    end else if (if_stall_req) begin
                        pause_c = stall_upto(PAUSE_IF);
                    end
                end
            end
            S_REDIR: begin
                pause_c = stall_upto(PAUSE_PC);
                if (redir.redirect_ack) begin
                    redir_done = 1'b1;
                    state_n    = S_RUN;
                end
            end
        endcase
    end

    // Combinational outputs are masked so reset silences them at once.
    assign pause = rst ? pause_c : '0;
    assign flush = rst & flush_c;

    pipe_div_timer #(
        .DIV_LATENCY (DIV_LATENCY),
        .CNT_W       (CNT_W)
    ) u_div_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .freeze (mem_stall_req),
        .clear  (flush_c),
        .busy   (div_busy),
        .done   (div_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_valid <= 1'b0;
            pc_q     <= '0;
        end else if (redir_load) begin
            pc_valid <= 1'b1;
            pc_q     <= pc_tgt;
        end else if (redir_done) begin
            pc_valid <= 1'b0;
        end
    end

    assign redir.redirect_pc_valid = pc_valid;
    assign redir.redirect_pc       = pc_q;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pause[PAUSE_PC]) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed bench for pipe_stall_ctrl.
// obs packs {pause, flush, redirect_pc_valid, div_busy, div_done}.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        mem_stall_req;
    logic        ex_div_start;
    logic [5:0]  pause;
    logic        flush;
    logic        div_busy;
    logic        div_done;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    logic [9:0] obs;
    logic [9:0] want;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .id_stall_req  (id_stall_req),
        .ex_stall_req  (ex_stall_req),
        .mem_stall_req (mem_stall_req),
        .ex_div_start  (ex_div_start),
        .redir         (bus),
        .pause         (pause),
        .flush         (flush),
        .div_busy      (div_busy),
        .div_done      (div_done)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    assign obs = {pause, flush, bus.redirect_pc_valid, div_busy, div_done};

    task automatic clr_in();
        if_stall_req     = 1'b0;
        id_stall_req     = 1'b0;
        ex_stall_req     = 1'b0;
        mem_stall_req    = 1'b0;
        ex_div_start     = 1'b0;
        bus.excp_valid   = 1'b0;
        bus.excp_is_ertn = 1'b0;
        bus.excp_entry   = 32'h0;
        bus.csr_era      = 32'h0;
        bus.redirect_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        id_stall_req   = 1'b1;
        ex_div_start   = 1'b1;
        bus.excp_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errs++;
            $display("FAIL reset_hold obs=%b want=%b", obs, 10'b0);
        end
        checks++;
        if (bus.redirect_pc !== 32'h0) begin
            errs++;
            $display("FAIL reset_pc got=%h want=0", bus.redirect_pc);
        end
        clr_in();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errs++;
            $display("FAIL reset_rel obs=%b want=%b", obs, 10'b0);
        end
    endtask

    task automatic test_id_stall();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            id_stall_req = 1'b1;
            #1;
            want = {6'b000111, 4'b0000};
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL id_stall c%0d obs=%b want=%b", i, obs, want);
            end
        end
        @(negedge clk);
        id_stall_req = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errs++;
            $display("FAIL id_stall_end obs=%b want=%b", obs, 10'b0);
        end
    endtask

    task automatic test_merge();
        logic [5:0] exp_p [5];
        exp_p[0] = 6'b011111;
        exp_p[1] = 6'b000111;
        exp_p[2] = 6'b000011;
        exp_p[3] = 6'b001111;
        exp_p[4] = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            id_stall_req  = (i <= 1);
            mem_stall_req = (i == 0);
            if_stall_req  = (i == 2);
            ex_stall_req  = (i == 3);
            #1;
            want = {exp_p[i], 4'b0000};
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL merge c%0d obs=%b want=%b", i, obs, want);
            end
        end
        clr_in();
    endtask

    task automatic test_divide();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            ex_div_start = (i <= 17);
            #1;
            if (i == 0) want = {6'b001111, 4'b0000};
            else if (i <= 16) want = {6'b001111, 4'b0010};
            else if (i == 17) want = {6'b000000, 4'b0001};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL divide c%0d obs=%b want=%b", i, obs, want);
            end
        end
        clr_in();
    endtask

    task automatic test_divide_freeze();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            ex_div_start  = (i <= 20);
            mem_stall_req = (i >= 5 && i <= 7);
            #1;
            if (i == 0) want = {6'b001111, 4'b0000};
            else if (i >= 5 && i <= 7) want = {6'b011111, 4'b0010};
            else if (i <= 19) want = {6'b001111, 4'b0010};
            else if (i == 20) want = {6'b000000, 4'b0001};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL div_freeze c%0d obs=%b want=%b", i, obs, want);
            end
        end
        clr_in();
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        ex_div_start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ex_div_start = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errs++;
            $display("FAIL rst_mid_div obs=%b want=%b", obs, 10'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (obs !== 10'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_div_after activity=%b want=0", seen);
        end
    endtask

    task automatic test_exception();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.excp_valid   = (i == 0 || i == 2);
            bus.excp_entry   = (i == 2) ? 32'hDEAD_0000 : 32'h1C00_8000;
            id_stall_req     = (i == 2);
            bus.redirect_ack = (i == 3);
            #1;
            if (i == 0) want = {6'b000000, 4'b1000};
            else if (i <= 3) want = {6'b000001, 4'b0100};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL excp c%0d obs=%b want=%b", i, obs, want);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus.redirect_pc !== 32'h1C00_8000) begin
                    errs++;
                    $display("FAIL excp_pc c%0d got=%h want=1c008000",
                             i, bus.redirect_pc);
                end
            end
        end
        clr_in();
    endtask

    task automatic test_ertn();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.excp_valid   = (i == 0);
            bus.excp_is_ertn = (i == 0);
            bus.csr_era      = 32'h1C00_0104;
            bus.excp_entry   = 32'h1C00_8000;
            bus.redirect_ack = (i == 1);
            #1;
            if (i == 0) want = {6'b000000, 4'b1000};
            else if (i == 1) want = {6'b000001, 4'b0100};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL ertn c%0d obs=%b want=%b", i, obs, want);
            end
        end
        checks++;
        if (bus.redirect_pc !== 32'h1C00_0104) begin
            errs++;
            $display("FAIL ertn_pc got=%h want=1c000104", bus.redirect_pc);
        end
        clr_in();
    endtask

    task automatic test_excp_mem_wait();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.excp_valid   = (i <= 1);
            bus.excp_entry   = 32'h1C00_2000;
            mem_stall_req    = (i == 0);
            bus.redirect_ack = (i == 2);
            #1;
            if (i == 0) want = {6'b011111, 4'b0000};
            else if (i == 1) want = {6'b000000, 4'b1000};
            else if (i == 2) want = {6'b000001, 4'b0100};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL excp_wait c%0d obs=%b want=%b", i, obs, want);
            end
        end
        checks++;
        if (bus.redirect_pc !== 32'h1C00_2000) begin
            errs++;
            $display("FAIL excp_wait_pc got=%h want=1c002000",
                     bus.redirect_pc);
        end
        clr_in();
    endtask

    task automatic test_excp_during_div();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ex_div_start     = (i <= 5);
            bus.excp_valid   = (i == 5);
            bus.excp_entry   = 32'h1C00_8000;
            bus.redirect_ack = (i == 6);
            #1;
            if (i == 0) want = {6'b001111, 4'b0000};
            else if (i <= 4) want = {6'b001111, 4'b0010};
            else if (i == 5) want = {6'b000000, 4'b1010};
            else if (i == 6) want = {6'b000001, 4'b0100};
            else want = 10'b0;
            checks++;
            if (obs !== want) begin
                errs++;
                $display("FAIL excp_div c%0d obs=%b want=%b", i, obs, want);
            end
        end
        clr_in();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (div_done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL excp_div_done seen=%b want=0", seen);
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_id_stall();
        test_merge();
        test_divide();
        test_divide_freeze();
        test_reset_mid_div();
        test_exception();
        test_ertn();
        test_excp_mem_wait();
        test_excp_during_div();
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (perf_flush_cnt !== 32'd4) begin
            errs++;
            $display("FAIL perf_flush got=%0d want=4", perf_flush_cnt);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
